// File: rtl/jtag_dma_controller_if.sv
// rtl/jtag_dma_controller_if.sv - bus arbitration, command, data and status signals of the jtag DMA controller
interface jtag_dma_controller_if;
   logic        bus_request;
   logic        bus_grant;
   logic        bus_begin_transaction;
   logic [31:0] bus_address;
   logic [3:0]  bus_byte_enables;
   logic [7:0]  bus_burst_size;
   logic        bus_read_n_write;
   logic        bus_end_transaction_out;
   logic [31:0] bus_data_out;
   logic        bus_data_valid_out;
   logic [31:0] bus_data_in;
   logic        bus_data_valid_in;
   logic        bus_busy;
   logic        bus_end_transaction_in;
   logic        bus_error;

   modport master (
      output bus_request, bus_begin_transaction, bus_address, bus_byte_enables, bus_burst_size,
             bus_read_n_write, bus_end_transaction_out, bus_data_out, bus_data_valid_out,
      input  bus_grant, bus_data_in, bus_data_valid_in, bus_busy, bus_end_transaction_in, bus_error
   );

   modport slave (
      input  bus_request, bus_begin_transaction, bus_address, bus_byte_enables, bus_burst_size,
             bus_read_n_write, bus_end_transaction_out, bus_data_out, bus_data_valid_out,
      output bus_grant, bus_data_in, bus_data_valid_in, bus_busy, bus_end_transaction_in, bus_error
   );
endinterface

// File: rtl/jtag_dma_controller.sv
// rtl/jtag_dma_controller.sv - burst DMA engine moving 32-bit words between a local buffer and the system bus
// Writes stream buffer words onto the bus; reads capture bus data into the buffer, split into bursts.
module jtag_dma_controller #(
   parameter int unsigned ADDR_STEP = 4
) (
   input  logic        system_clk,
   input  logic        reset,
   input  logic        launch_write,
   input  logic        launch_read,
   input  logic [31:0] start_address,
   input  logic [3:0]  byte_enable,
   input  logic [7:0]  burst_size,
   input  logic [7:0]  block_size,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  words_done,
   output logic [8:0]  buf_address,
   output logic        buf_write_enable,
   output logic [31:0] buf_data_out,
   input  logic [31:0] buf_data_in,
   jtag_dma_controller_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQUEST, S_BEGIN, S_WRITE_DATA, S_READ_DATA, S_END_BURST, S_DONE
   } state_t;

   localparam logic [31:0] STEP = 32'(ADDR_STEP);

   state_t      state_q;
   logic        rnw_q;
   logic [31:0] addr_q;
   logic [3:0]  be_q;
   logic [7:0]  burst_q;
   logic [8:0]  remaining_q;
   logic [8:0]  beats_q;
   logic [8:0]  beat_cnt_q;
   logic [7:0]  words_q;
   logic        busy_q;
   logic        done_q;
   logic        error_q;
   logic [7:0]  buf_addr_q;
   logic        buf_we_q;
   logic [31:0] buf_wdata_q;
   logic        req_q;
   logic        begin_q;
   logic [31:0] cmd_addr_q;
   logic [3:0]  cmd_be_q;
   logic [7:0]  cmd_burst_q;
   logic        cmd_rnw_q;
   logic        end_out_q;
   logic [31:0] wdata_q;
   logic        wvalid_q;

   logic [8:0]  burst_beats_d;
   logic [8:0]  beats_d;
   logic [8:0]  remaining_d;
   logic        last_beat_d;
   logic        consume_d;
   logic        abort_d;
   logic [7:0]  fetch_addr_d;

   assign burst_beats_d = {1'b0, burst_q} + 9'd1;
   assign beats_d       = (burst_beats_d < remaining_q) ? burst_beats_d : remaining_q;
   assign remaining_d   = remaining_q - beats_q;
   assign last_beat_d   = (beat_cnt_q + 9'd1) == beats_q;
   assign abort_d       = bus.bus_error &&
                          (state_q == S_BEGIN || state_q == S_WRITE_DATA || state_q == S_READ_DATA);

   // Buffer reads take a cycle, so the address runs one word ahead of the word being loaded.
   assign consume_d    = !rnw_q && !bus.bus_error &&
                         ((state_q == S_BEGIN) ||
                          (state_q == S_WRITE_DATA && !bus.bus_busy && !last_beat_d));
   assign fetch_addr_d = buf_addr_q + {7'd0, consume_d};

   always_ff @(posedge system_clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rnw_q       <= 1'b0;
         addr_q      <= '0;
         be_q        <= '0;
         burst_q     <= '0;
         remaining_q <= '0;
         beats_q     <= '0;
         beat_cnt_q  <= '0;
         words_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         buf_addr_q  <= '0;
         buf_we_q    <= 1'b0;
         buf_wdata_q <= '0;
         req_q       <= 1'b0;
         begin_q     <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_be_q    <= '0;
         cmd_burst_q <= '0;
         cmd_rnw_q   <= 1'b0;
         end_out_q   <= 1'b0;
         wdata_q     <= '0;
         wvalid_q    <= 1'b0;
      end else begin
         begin_q     <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_be_q    <= '0;
         cmd_burst_q <= '0;
         cmd_rnw_q   <= 1'b0;
         end_out_q   <= 1'b0;
         buf_we_q    <= 1'b0;
         done_q      <= 1'b0;
         if (consume_d) begin
            buf_addr_q <= buf_addr_q + 8'd1;
         end
         if (abort_d) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            error_q  <= 1'b1;
            req_q    <= 1'b0;
            wvalid_q <= 1'b0;
            wdata_q  <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (launch_write || launch_read) begin
                     rnw_q       <= !launch_write;
                     addr_q      <= start_address;
                     be_q        <= byte_enable;
                     burst_q     <= burst_size;
                     remaining_q <= {1'b0, block_size};
                     words_q     <= '0;
                     error_q     <= 1'b0;
                     busy_q      <= 1'b1;
                     buf_addr_q  <= '0;
                     if (block_size == 8'd0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= S_REQUEST;
                        req_q   <= 1'b1;
                     end
                  end
               end
               S_REQUEST: begin
                  if (bus.bus_grant) begin
                     state_q     <= S_BEGIN;
                     beats_q     <= beats_d;
                     beat_cnt_q  <= '0;
                     begin_q     <= 1'b1;
                     cmd_addr_q  <= addr_q;
                     cmd_be_q    <= be_q;
                     cmd_burst_q <= 8'(beats_d - 9'd1);
                     cmd_rnw_q   <= rnw_q;
                  end
               end
               S_BEGIN: begin
                  if (rnw_q) begin
                     state_q <= S_READ_DATA;
                  end else begin
                     state_q  <= S_WRITE_DATA;
                     wvalid_q <= 1'b1;
                     wdata_q  <= buf_data_in;
                  end
               end
               S_WRITE_DATA: begin
                  if (!bus.bus_busy) begin
                     words_q    <= words_q + 8'd1;
                     beat_cnt_q <= beat_cnt_q + 9'd1;
                     if (last_beat_d) begin
                        wvalid_q  <= 1'b0;
                        wdata_q   <= '0;
                        end_out_q <= 1'b1;
                        req_q     <= 1'b0;
                        state_q   <= S_END_BURST;
                     end else begin
                        wdata_q <= buf_data_in;
                     end
                  end
               end
               S_READ_DATA: begin
                  if (bus.bus_data_valid_in) begin
                     buf_we_q    <= 1'b1;
                     buf_wdata_q <= bus.bus_data_in;
                     buf_addr_q  <= words_q;
                     words_q     <= words_q + 8'd1;
                  end
                  if (bus.bus_end_transaction_in) begin
                     req_q   <= 1'b0;
                     state_q <= S_END_BURST;
                  end
               end
               S_END_BURST: begin
                  addr_q      <= addr_q + ({23'd0, beats_q} * STEP);
                  remaining_q <= remaining_d;
                  buf_addr_q  <= words_q;
                  if (remaining_d != 9'd0) begin
                     state_q <= S_REQUEST;
                     req_q   <= 1'b1;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
               S_DONE: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign error            = error_q;
   assign words_done       = words_q;
   assign buf_address      = {1'b0, fetch_addr_d};
   assign buf_write_enable = buf_we_q;
   assign buf_data_out     = buf_wdata_q;

   assign bus.bus_request             = req_q;
   assign bus.bus_begin_transaction   = begin_q;
   assign bus.bus_address             = cmd_addr_q;
   assign bus.bus_byte_enables        = cmd_be_q;
   assign bus.bus_burst_size          = cmd_burst_q;
   assign bus.bus_read_n_write        = cmd_rnw_q;
   assign bus.bus_end_transaction_out = end_out_q;
   assign bus.bus_data_out            = wdata_q;
   assign bus.bus_data_valid_out      = wvalid_q;

endmodule

// File: tb/tb_jtag_dma_controller.sv
// tb/tb_jtag_dma_controller.sv - self-checking bench for jtag_dma_controller
`timescale 1ns/1ps
module tb_jtag_dma_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        launch_write, launch_read;
   logic [31:0] start_address;
   logic [3:0]  byte_enable;
   logic [7:0]  burst_size, block_size;
   logic        busy, done, error;
   logic [7:0]  words_done;
   logic [8:0]  buf_address;
   logic        buf_write_enable;
   logic [31:0] buf_data_out;
   logic [31:0] buf_data_in;

   logic [31:0] src_mem [256];
   logic [31:0] dst_mem [256];

   int n_chk = 0;
   int n_fail = 0;

   jtag_dma_controller_if bus_if ();

   jtag_dma_controller #(.ADDR_STEP(4)) dut (
      .system_clk(clk), .reset(rst),
      .launch_write(launch_write), .launch_read(launch_read),
      .start_address(start_address), .byte_enable(byte_enable),
      .burst_size(burst_size), .block_size(block_size),
      .busy(busy), .done(done), .error(error), .words_done(words_done),
      .buf_address(buf_address), .buf_write_enable(buf_write_enable),
      .buf_data_out(buf_data_out), .buf_data_in(buf_data_in),
      .bus(bus_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (buf_write_enable) dst_mem[buf_address[7:0]] <= buf_data_out;
      buf_data_in <= src_mem[buf_address[7:0]];
   end

   typedef struct {
      string       name;
      bit          rnw;
      bit          both;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [7:0]  burst;
      logic [7:0]  block;
      int          gdelay;
      int          busy_beat;
      int          busy_len;
      int          err_beat;
      bit          gaps;
      int          relaunch_at;
      int          rst_at;
      int          exp_words;
      bit          exp_error;
   } vec_t;

   localparam int NV = 14;
   vec_t tv [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic outs_or();
      return |{busy, done, error, words_done, buf_address, buf_write_enable, buf_data_out,
               bus_if.bus_request, bus_if.bus_begin_transaction, bus_if.bus_address,
               bus_if.bus_byte_enables, bus_if.bus_burst_size, bus_if.bus_read_n_write,
               bus_if.bus_end_transaction_out, bus_if.bus_data_out, bus_if.bus_data_valid_out};
   endfunction

   task automatic clear_bus();
      bus_if.bus_grant = 1'b0;
      bus_if.bus_data_in = '0;
      bus_if.bus_data_valid_in = 1'b0;
      bus_if.bus_busy = 1'b0;
      bus_if.bus_end_transaction_in = 1'b0;
      bus_if.bus_error = 1'b0;
   endtask

   task automatic run(input vec_t v);
      logic [31:0] e_addr [$];
      int          e_beats [$];
      logic [31:0] exp_mem [256];
      logic [31:0] a, d;
      int rem, b, nb, cum, exp_begins, exp_ends, errs;
      int bi, beat_no, rd_left, req_cnt, busy_left, ends, drops, cyc, lat;
      bit rd_end, saw_low, req_seen, cmd_leak, finished, wr;

      // Expected burst plan: split the block into chunks of at most burst+1 words.
      rem = int'(v.block);
      a = v.addr;
      while (rem > 0) begin
         b = (int'(v.burst) + 1 < rem) ? int'(v.burst) + 1 : rem;
         e_addr.push_back(a);
         e_beats.push_back(b);
         a = a + 32'(b * 4);
         rem -= b;
      end
      wr = !v.rnw || v.both;
      exp_begins = e_beats.size();
      exp_ends = wr ? exp_begins : 0;
      if (v.err_beat > 0) begin
         nb = 0;
         cum = 0;
         foreach (e_beats[i]) if (cum < v.err_beat) begin nb++; cum += e_beats[i]; end
         exp_begins = nb;
         exp_ends = wr ? nb - 1 : 0;
      end

      bi = 0; beat_no = 1; rd_left = 0; req_cnt = 0; busy_left = v.busy_len;
      ends = 0; drops = 0; cyc = 0; lat = 0;
      rd_end = 0; saw_low = 0; req_seen = 0; cmd_leak = 0; finished = 0;

      @(negedge clk);
      start_address = v.addr; byte_enable = v.be; burst_size = v.burst; block_size = v.block;
      launch_write = wr;
      launch_read = v.rnw || v.both;
      @(negedge clk);
      start_address = $urandom; byte_enable = 4'($urandom);
      burst_size = 8'($urandom); block_size = 8'($urandom);

      while (!finished && cyc < 3000) begin
         cyc++;
         launch_write = (v.relaunch_at == cyc);
         launch_read = (v.relaunch_at == cyc);
         if (v.rst_at == cyc) begin
            rst = 1'b1;
            #1;
            chk({v.name, "_reset_outputs_zero"}, outs_or(), 0);
            clear_bus();
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (bus_if.bus_request) req_seen = 1; else saw_low = 1;
         if (bus_if.bus_begin_transaction) begin
            if (bi < e_addr.size()) begin
               chk({v.name, "_begin_addr"}, bus_if.bus_address, e_addr[bi]);
               chk({v.name, "_begin_burst"}, bus_if.bus_burst_size, e_beats[bi] - 1);
               chk({v.name, "_begin_rnw"}, bus_if.bus_read_n_write, v.rnw);
               chk({v.name, "_begin_be"}, bus_if.bus_byte_enables, v.be);
               rd_left = e_beats[bi];
            end
            if (bi > 0 && saw_low) drops++;
            bi++;
            saw_low = 0;
         end else if (|{bus_if.bus_address, bus_if.bus_byte_enables, bus_if.bus_burst_size,
                        bus_if.bus_read_n_write}) begin
            cmd_leak = 1;
         end
         if (bus_if.bus_end_transaction_out) ends++;
         if (done) begin
            finished = 1;
            lat = cyc;
            chk({v.name, "_words_done"}, words_done, v.exp_words);
            chk({v.name, "_error"}, error, v.exp_error);
            chk({v.name, "_req_at_done"}, bus_if.bus_request, 0);
            chk({v.name, "_busy_at_done"}, busy, 1);
         end else begin
            clear_bus();
            if (bus_if.bus_request) begin
               req_cnt++;
               bus_if.bus_grant = (req_cnt >= v.gdelay);
            end else begin
               req_cnt = 0;
            end
            if (wr && bus_if.bus_data_valid_out) begin
               chk({v.name, "_wdata"}, bus_if.bus_data_out, src_mem[(beat_no - 1) % 256]);
               if (beat_no == v.err_beat) bus_if.bus_error = 1'b1;
               else if (beat_no == v.busy_beat && busy_left > 0) begin
                  bus_if.bus_busy = 1'b1;
                  busy_left--;
               end else beat_no++;
            end
            if (!wr && rd_left > 0 && !bus_if.bus_begin_transaction) begin
               if (beat_no == v.err_beat) bus_if.bus_error = 1'b1;
               else if (!(v.gaps && $urandom_range(0, 3) == 0)) begin
                  d = $urandom;
                  bus_if.bus_data_in = d;
                  bus_if.bus_data_valid_in = 1'b1;
                  exp_mem[(beat_no - 1) % 256] = d;
                  beat_no++;
                  rd_left--;
                  if (rd_left == 0) rd_end = 1;
               end
            end else if (!wr && rd_end) begin
               bus_if.bus_end_transaction_in = 1'b1;
               rd_end = 0;
            end
            @(negedge clk);
         end
      end
      clear_bus();
      launch_write = 1'b0;
      launch_read = 1'b0;
      chk({v.name, "_done_seen"}, finished, 1);
      if (!finished) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         return;
      end
      @(negedge clk);
      chk({v.name, "_done_one_cycle"}, done, 0);
      chk({v.name, "_idle_after_done"}, busy, 0);
      chk({v.name, "_begin_count"}, bi, exp_begins);
      chk({v.name, "_end_pulses"}, ends, exp_ends);
      chk({v.name, "_req_drops"}, drops, (exp_begins > 0) ? exp_begins - 1 : 0);
      chk({v.name, "_cmd_zero_outside_begin"}, cmd_leak, 0);
      if (v.block == 8'd0) begin
         chk({v.name, "_no_request"}, req_seen, 0);
         chk({v.name, "_done_latency_le2"}, (lat <= 2), 1);
      end
      if (!wr) begin
         errs = 0;
         for (int i = 0; i < v.exp_words; i++) if (dst_mem[i] !== exp_mem[i]) errs++;
         chk({v.name, "_read_buffer"}, errs, 0);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      rst = 1'b1;
      launch_write = 1'b0; launch_read = 1'b0;
      start_address = '0; byte_enable = '0; burst_size = '0; block_size = '0;
      clear_bus();
      for (int i = 0; i < 256; i++) src_mem[i] = $urandom;

      //        name            rnw  both addr           be     burst   block  gd bb bl eb gaps rl rs words err
      tv[0]  = '{"wr_basic",    1'b0, 1'b0, 32'h0000_0100, 4'hF, 8'd3,   8'd4,  2, 0, 0, 0, 1'b0, 0, 0, 4,  1'b0};
      tv[1]  = '{"rd_split",    1'b1, 1'b0, 32'h0000_1000, 4'hF, 8'd3,   8'd10, 1, 0, 0, 0, 1'b0, 0, 0, 10, 1'b0};
      tv[2]  = '{"wr_busy",     1'b0, 1'b0, 32'h0000_0200, 4'h3, 8'd7,   8'd6,  1, 2, 3, 0, 1'b0, 0, 0, 6,  1'b0};
      tv[3]  = '{"zero_block",  1'b0, 1'b0, 32'h0000_0300, 4'hF, 8'd3,   8'd0,  1, 0, 0, 0, 1'b0, 0, 0, 0,  1'b0};
      tv[4]  = '{"both_launch", 1'b0, 1'b1, 32'h0000_0400, 4'hC, 8'd1,   8'd5,  1, 0, 0, 0, 1'b0, 0, 0, 5,  1'b0};
      tv[5]  = '{"relaunch",    1'b0, 1'b0, 32'h0000_0500, 4'hF, 8'd2,   8'd8,  1, 0, 0, 0, 1'b0, 3, 0, 8,  1'b0};
      tv[6]  = '{"rd_error",    1'b1, 1'b0, 32'h0000_0600, 4'hF, 8'd7,   8'd8,  1, 0, 0, 3, 1'b0, 0, 0, 2,  1'b1};
      tv[7]  = '{"wr_error",    1'b0, 1'b0, 32'h0000_0700, 4'hF, 8'd7,   8'd6,  1, 0, 0, 4, 1'b0, 0, 0, 3,  1'b1};
      tv[8]  = '{"wr_reset",    1'b0, 1'b0, 32'h0000_0800, 4'hF, 8'd3,   8'd8,  1, 0, 0, 0, 1'b0, 0, 4, 0,  1'b0};
      tv[9]  = '{"rd_after_rst",1'b1, 1'b0, 32'h0000_0900, 4'h1, 8'd3,   8'd8,  1, 0, 0, 0, 1'b0, 0, 0, 8,  1'b0};
      tv[10] = '{"rd_reset",    1'b1, 1'b0, 32'h0000_0A00, 4'hF, 8'd3,   8'd8,  1, 0, 0, 0, 1'b0, 0, 5, 0,  1'b0};
      tv[11] = '{"wr_after_rst",1'b0, 1'b0, 32'h0000_0B00, 4'hF, 8'd0,   8'd5,  2, 0, 0, 0, 1'b0, 0, 0, 5,  1'b0};
      tv[12] = '{"rd_burst255", 1'b1, 1'b0, 32'h0000_0C00, 4'hF, 8'd255, 8'd20, 3, 0, 0, 0, 1'b1, 0, 0, 20, 1'b0};
      tv[13] = '{"wr_addr_wrap",1'b0, 1'b0, 32'hFFFF_FFF8, 4'hF, 8'd1,   8'd6,  1, 0, 0, 0, 1'b0, 0, 0, 6,  1'b0};

      repeat (2) @(negedge clk);
      chk("reset_outputs_zero", outs_or(), 0);
      launch_write = 1'b1;
      block_size = 8'd3;
      @(negedge clk);
      chk("launch_during_reset_ignored", busy, 0);
      launch_write = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_after_reset_release", busy, 0);

      for (int i = 0; i < NV; i++) run(tv[i]);

      for (int r = 0; r < 10; r++) begin
         rv.name = "random";
         rv.rnw = 1'($urandom_range(0, 1));
         rv.both = 1'b0;
         rv.addr = $urandom & 32'hFFFF_FFFC;
         rv.be = 4'($urandom);
         rv.burst = ($urandom_range(0, 4) == 0) ? 8'd255 : 8'($urandom_range(0, 7));
         rv.block = 8'($urandom_range(1, 40));
         rv.gdelay = $urandom_range(1, 3);
         rv.busy_beat = $urandom_range(1, int'(rv.block));
         rv.busy_len = $urandom_range(0, 2);
         rv.err_beat = 0;
         rv.gaps = 1'b1;
         rv.relaunch_at = 0;
         rv.rst_at = 0;
         rv.exp_words = int'(rv.block);
         rv.exp_error = 1'b0;
         run(rv);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
